// File: rtl/dma_mem_pkg.sv
// Shared types and constants for the DMA memory responder.
package dma_mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } dma_state_e;

    localparam int unsigned WaitCntW    = 4;
    localparam logic [31:0] OorReadData = 32'h0000_0000;
    localparam logic [15:0] WrCountMax  = 16'hFFFF;

    // Offset is addr - base (unsigned wrap), so addresses below the base land out of range too.
    function automatic logic in_window(input logic [31:0] offset, input int unsigned aw);
        return (offset >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/dma_mem_slave_if.sv
// Single-word request/ack bus between the disk DMA master and the memory responder.
interface dma_mem_slave_if;
    logic        s_cyc;
    logic        s_we;
    logic [3:0]  s_strb;
    logic [31:0] s_addr;
    logic [31:0] s_data_i;
    logic        s_ack;
    logic [31:0] s_data_o;

    modport master (
        output s_cyc, s_we, s_strb, s_addr, s_data_i,
        input  s_ack, s_data_o
    );

    modport slave (
        input  s_cyc, s_we, s_strb, s_addr, s_data_i,
        output s_ack, s_data_o
    );
endinterface

// File: rtl/dma_mem_ram.sv
// 2^AW x 32 word RAM: synchronous byte-lane writes, asynchronous read, no reset.
module dma_mem_ram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // Update only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dma_mem_slave.sv
// Memory-side responder: FSM with wait states, request latches, window decode,
// saturating write counter and sticky decode-error flag.
module dma_mem_slave
    import dma_mem_pkg::*;
#(
    parameter int unsigned AW          = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dma_mem_slave_if.slave   bus,
    output logic [15:0]      wr_count,
    output logic             err,
    input  logic             err_clear
);

    localparam logic [1:0] IDLE = StIdle;
    localparam logic [1:0] WAIT = StWait;
    localparam logic [1:0] ACK  = StAck;

    logic [1:0]          state_q, state_d;
    logic [WaitCntW-1:0] cnt_q, cnt_d;
    logic                we_q;
    logic [3:0]          strb_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         data_o_q, data_o_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic                err_q, err_d;

    logic                accept;
    logic                req_we;
    logic [31:0]         req_addr;
    logic [31:0]         req_offset;
    logic                req_in_range;
    logic [AW-1:0]       req_index;
    logic                commit;
    logic [3:0]          ram_we;
    logic [31:0]         ram_rdata;

    assign accept = (state_q == IDLE) && bus.s_cyc;

    // With no wait states the read data must be fetched while the request is still on the bus.
    assign req_we       = (state_q == IDLE) ? bus.s_we : we_q;
    assign req_addr     = (state_q == IDLE) ? bus.s_addr : addr_q;
    assign req_offset   = req_addr - BASE_ADDR;
    assign req_in_range = in_window(req_offset, AW);
    assign req_index    = req_offset[AW+1:2];

    assign commit = (state_q == ACK) && we_q && req_in_range;
    assign ram_we = commit ? strb_q : 4'b0000;

    dma_mem_ram #(
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (req_index),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Next-state logic: accept, count down wait states, abort on dropped cyc, single ACK.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.s_cyc) begin
                    cnt_d   = WaitCntW'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!bus.s_cyc) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= WaitCntW'(1)) begin
                    state_d = ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - WaitCntW'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Read data is registered on entry to ACK and zero in every other cycle.
    always_comb begin
        data_o_d = 32'h0;
        if ((state_d == ACK) && !req_we) begin
            data_o_d = req_in_range ? ram_rdata : OorReadData;
        end
    end

    // Counter counts committed writes with any lane enabled; err set wins over clear.
    always_comb begin
        wr_count_d = wr_count_q;
        if (commit && (strb_q != 4'b0000) && (wr_count_q != WrCountMax)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        err_d = err_q;
        if ((state_q == ACK) && !req_in_range) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_o_q   <= 32'h0;
            wr_count_q <= 16'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_o_q   <= data_o_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
        end
    end

    // Request latches, loaded when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            strb_q  <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= bus.s_we;
            strb_q  <= bus.s_strb;
            addr_q  <= bus.s_addr;
            wdata_q <= bus.s_data_i;
        end
    end

    assign bus.s_ack    = (state_q == ACK);
    assign bus.s_data_o = data_o_q;
    assign wr_count     = wr_count_q;
    assign err          = err_q;

endmodule
